// File: rtl/ascon_permutation_ctrl.sv
// Round sequencer for the ASCON permutation: owns the 320-bit state register and
// steps the round index for p^12 / p^8 / p^6. Word xi occupies bits [64*i+63 : 64*i].
module ascon_permutation_ctrl (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic [319:0] state_i,
  input  logic [319:0] round_state_i,
  output logic [3:0]   round_o,
  output logic [319:0] state_o,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  fsm_t         fsm_q;
  logic [3:0]   cnt_q;
  logic [319:0] state_q;
  logic         ready_q;
  logic         busy_q;
  logic         done_q;
  logic [3:0]   first_round;

  // Every permutation ends on round 11; shorter ones simply start later.
  always_comb begin
    first_round = 4'd0;
    case (mode_i)
      2'b01:   first_round = 4'd4;
      2'b10:   first_round = 4'd6;
      default: first_round = 4'd0;
    endcase
  end

  // NOTE: all state, including the wide state register, is updated with non-blocking
  // assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            cnt_q   <= first_round;
            fsm_q   <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          state_q <= round_state_i;
          if (cnt_q == LAST_ROUND) begin
            cnt_q  <= 4'd0;
            fsm_q  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          fsm_q   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          fsm_q   <= IDLE;
          cnt_q   <= 4'd0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The counter is zero outside RUN, so it drives the round index directly.
  assign round_o = cnt_q;
  assign state_o = state_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
